// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the demand-driven intersection phase scheduler:
//   - state_e   : phase encoding, also driven out on the debug 'phase' port
//   - LIGHTS_*  : lamp bus patterns {A_red, A_yel, A_grn, B_red, B_yel, B_grn}
//   - ROAD_*    : values of the 1-bit last-road register
//   - lights_of : lamp pattern for a given phase
package traffic_pkg;

  typedef enum logic [2:0] {
    AG  = 3'd0,
    AY  = 3'd1,
    RAB = 3'd2,
    BG  = 3'd3,
    BY  = 3'd4,
    RBA = 3'd5,
    PW  = 3'd6
  } state_e;

  localparam logic [5:0] LIGHTS_AG     = 6'b001100;
  localparam logic [5:0] LIGHTS_AY     = 6'b010100;
  localparam logic [5:0] LIGHTS_BG     = 6'b100001;
  localparam logic [5:0] LIGHTS_BY     = 6'b100010;
  localparam logic [5:0] LIGHTS_ALLRED = 6'b100100;

  localparam logic ROAD_A = 1'b0;
  localparam logic ROAD_B = 1'b1;

  function automatic logic [5:0] lights_of(input state_e s);
    case (s)
      AG:      lights_of = LIGHTS_AG;
      AY:      lights_of = LIGHTS_AY;
      BG:      lights_of = LIGHTS_BG;
      BY:      lights_of = LIGHTS_BY;
      default: lights_of = LIGHTS_ALLRED;  // RAB, RBA, PW
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
//   Free-running divider producing a one-cycle 'tick' every DIV clocks.
//   The counter runs 0..DIV-1; tick is high while it sits at DIV-1, so the
//   first tick lands DIV cycles after reset release.
// Ports:
//   clk   in  system clock
//   clr_n in  asynchronous active-low reset
//   tick  out one-cycle strobe, once per DIV cycles
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic clr_n,
  output logic tick
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] CNT_LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//   Demand-driven two-road intersection controller with a latched pedestrian
//   request and an emergency preempt. Phase durations are counted in ticks
//   from tick_prescaler; the phase FSM only moves on tick cycles.
// Ports:
//   clk     in  system clock
//   clr_n   in  asynchronous active-low reset
//   car_a   in  vehicle present on road A (level, sampled on ticks)
//   car_b   in  vehicle present on road B (level, sampled on ticks)
//   ped_btn in  pedestrian request, latched every cycle
//   emg_req in  emergency preempt (level, sampled on ticks)
//   emg_dir in  preempt direction, 0 = road A, 1 = road B
//   lights  out {A_red, A_yel, A_grn, B_red, B_yel, B_grn}
//   walk    out pedestrian walk lamp
//   phase   out current state encoding (debug)
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW    = 2,
  parameter int ALLRED    = 1,
  parameter int WALK      = 3
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       car_a,
  input  logic       car_b,
  input  logic       ped_btn,
  input  logic       emg_req,
  input  logic       emg_dir,
  output logic [5:0] lights,
  output logic       walk,
  output logic [2:0] phase
);

  // "N ticks elapsed" is timer == N-1 on a tick. Greens can rest beyond
  // their minimum, so elapsed checks use >= against a saturating timer.
  localparam logic [7:0] GMIN_LAST = 8'(GREEN_MIN - 1);
  localparam logic [7:0] GMAX_LAST = 8'(GREEN_MAX - 1);
  localparam logic [7:0] YEL_LAST  = 8'(YELLOW - 1);
  localparam logic [7:0] AR_LAST   = 8'(ALLRED - 1);
  localparam logic [7:0] WALK_LAST = 8'(WALK - 1);

  logic       tick;
  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       ped_pend_q, ped_pend_d;
  logic       last_road_q, last_road_d;

  logic       enter;
  logic       emg_a, emg_b;
  logic       ag_exit, bg_exit;

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .clr_n(clr_n),
    .tick (tick)
  );

  assign emg_a = emg_req && (emg_dir == ROAD_A);
  assign emg_b = emg_req && (emg_dir == ROAD_B);

  // A preempt toward the road that is already green pins that green and
  // suppresses every timer-based exit.
  assign ag_exit = !emg_a &&
                   (emg_b || ((timer_q >= GMIN_LAST) && (car_b || ped_pend_q)));
  assign bg_exit = !emg_b &&
                   (emg_a ||
                    (timer_q >= GMAX_LAST) ||
                    ((timer_q >= GMIN_LAST) && (!car_b || car_a || ped_pend_q)));

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        AG:  if (ag_exit) state_d = AY;
        AY:  if (timer_q >= YEL_LAST) state_d = RAB;
        RAB: if (timer_q >= AR_LAST)
               state_d = (ped_pend_q && !emg_req) ? PW : BG;
        BG:  if (bg_exit) state_d = BY;
        BY:  if (timer_q >= YEL_LAST) state_d = RBA;
        RBA: if (timer_q >= AR_LAST)
               state_d = (ped_pend_q && !emg_req) ? PW : AG;
        PW:  if (timer_q >= WALK_LAST)
               state_d = (last_road_q == ROAD_B) ? BG : AG;
        default: state_d = AG;
      endcase
    end
  end

  assign enter = (state_d != state_q);

  always_comb begin
    timer_d = timer_q;
    if (enter)                        timer_d = '0;
    else if (tick && timer_q != 8'hFF) timer_d = timer_q + 8'd1;
  end

  // A press on the same cycle PW is entered is kept for the next crossing.
  always_comb begin
    ped_pend_d = ped_pend_q;
    if (ped_btn)                      ped_pend_d = 1'b1;
    else if (enter && state_d == PW)  ped_pend_d = 1'b0;
  end

  // Records the green that follows the current all-red, so PW knows where
  // to hand over.
  always_comb begin
    last_road_d = last_road_q;
    if (enter && state_d == RAB) last_road_d = ROAD_B;
    if (enter && state_d == RBA) last_road_d = ROAD_A;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= AG;
      timer_q     <= '0;
      ped_pend_q  <= 1'b0;
      last_road_q <= ROAD_A;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      ped_pend_q  <= ped_pend_d;
      last_road_q <= last_road_d;
    end
  end

  assign lights = lights_of(state_q);
  assign walk   = (state_q == PW);
  assign phase  = state_q;

endmodule
